// File: rtl/ahb_slave_mem.sv
// AHB responder backed by a byte-lane word memory, with configurable wait states
// and the two-cycle ERROR response for out-of-range or misaligned transfers.
module ahb_slave_mem #(
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HBURST,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {ST_OKAY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            dp_act_q, dp_act_d;
   logic            dp_wr_q, dp_wr_d;
   logic [AW-1:0]   dp_idx_q, dp_idx_d;
   logic [3:0]      dp_lanes_q, dp_lanes_d;

   logic            a_active;
   logic            a_illegal;
   logic [AW-1:0]   a_idx;
   logic [3:0]      a_lanes;
   logic            wr_commit;
   logic            fwd_hit;
   logic [AW-1:0]   rd_idx;
   logic [31:0]     rd_word;
   logic [31:0]     fwd_word;
   logic            unused_hburst;

   // Burst type carries no decode information for a simple memory responder.
   assign unused_hburst = ^HBURST;

   assign a_active  = HSEL && (HTRANS == 2'b10 || HTRANS == 2'b11);
   assign a_idx     = HADDR[AW+1:2];
   assign a_illegal = (HADDR[31:AW+2] != '0) || (HSIZE > 3'd2) ||
                      (HSIZE == 3'd1 && HADDR[0]) ||
                      (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

   always_comb begin
      a_lanes = 4'b1111;
      case (HSIZE)
         3'd0:    a_lanes = 4'b0001 << HADDR[1:0];
         3'd1:    a_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
         default: a_lanes = 4'b1111;
      endcase
   end

   // Writes commit on the edge that closes their data phase, i.e. while HREADY is high.
   assign wr_commit = ready_q && dp_act_q && dp_wr_q;
   assign rd_idx    = (state_q == ST_WAIT) ? dp_idx_q : a_idx;
   assign fwd_hit   = wr_commit && (dp_idx_q == rd_idx);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_WORDS];

         always_ff @(posedge HCLK) begin
            if (wr_commit && dp_lanes_q[gi])
               lane_mem[dp_idx_q] <= HWDATA[8*gi +: 8];
         end

         assign rd_word[8*gi +: 8]  = lane_mem[rd_idx];
         assign fwd_word[8*gi +: 8] = (fwd_hit && dp_lanes_q[gi]) ? HWDATA[8*gi +: 8]
                                                                  : rd_word[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = ready_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      dp_act_d   = dp_act_q;
      dp_wr_d    = dp_wr_q;
      dp_idx_d   = dp_idx_q;
      dp_lanes_d = dp_lanes_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_OKAY;
               ready_d = 1'b1;
               if (!dp_wr_q)
                  rdata_d = fwd_word;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
            ready_d = 1'b1;
            err_d   = 1'b1;
         end
         default: begin
            // OKAY and ERR2 both accept the next address phase.
            state_d  = ST_OKAY;
            ready_d  = 1'b1;
            err_d    = 1'b0;
            dp_act_d = 1'b0;
            dp_wr_d  = 1'b0;
            if (a_active && a_illegal) begin
               state_d = ST_ERR1;
               ready_d = 1'b0;
               err_d   = 1'b1;
            end else if (a_active) begin
               dp_act_d   = 1'b1;
               dp_wr_d    = HWRITE;
               dp_idx_d   = a_idx;
               dp_lanes_d = a_lanes;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  ready_d = 1'b0;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else if (!HWRITE) begin
                  rdata_d = fwd_word;
               end
            end
         end
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= ST_OKAY;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b1;
         err_q      <= 1'b0;
         rdata_q    <= 32'd0;
         dp_act_q   <= 1'b0;
         dp_wr_q    <= 1'b0;
         dp_idx_q   <= '0;
         dp_lanes_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         dp_act_q   <= dp_act_d;
         dp_wr_q    <= dp_wr_d;
         dp_idx_q   <= dp_idx_d;
         dp_lanes_q <= dp_lanes_d;
      end
   end

   assign HREADY = ready_q;
   assign HRESP  = {1'b0, err_q};
   assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) driven by a simple
// AHB master and checked against a byte-addressed memory model.
module tb_ahb_slave_mem;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst    [3];
   logic        hsel   [3];
   logic [1:0]  htrans [3];
   logic [2:0]  hburst [3];
   logic [2:0]  hsize  [3];
   logic        hwrite [3];
   logic [31:0] haddr  [3];
   logic [31:0] hwdata [3];
   logic        hready [3];
   logic [1:0]  hresp  [3];
   logic [31:0] hrdata [3];

   logic [7:0]  mdl [3][1024];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         ahb_slave_mem #(.MEM_WORDS(256), .WAIT_STATES(gi == 0 ? 0 : gi + 1)) u_dut (
            .HCLK   (clk),
            .HRESET (rst[gi]),
            .HSEL   (hsel[gi]),
            .HTRANS (htrans[gi]),
            .HBURST (hburst[gi]),
            .HSIZE  (hsize[gi]),
            .HWRITE (hwrite[gi]),
            .HADDR  (haddr[gi]),
            .HWDATA (hwdata[gi]),
            .HREADY (hready[gi]),
            .HRESP  (hresp[gi]),
            .HRDATA (hrdata[gi])
         );
      end
   endgenerate

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : d + 1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic bit illegal(input logic [2:0] size, input logic [31:0] addr);
      return (addr >= 32'd1024) || (size > 3'd2) ||
             (size == 3'd1 && addr % 2 != 0) || (size == 3'd2 && addr % 4 != 0);
   endfunction

   function automatic logic [31:0] mdl_word(input int d, input logic [31:0] addr);
      int base;
      base = int'(addr & ~32'd3);
      return {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
   endfunction

   task automatic mdl_write(input int d, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] data);
      int a;
      for (int j = 0; j < (1 << size); j++) begin
         a = int'(addr) + j;
         mdl[d][a] = data[8*(a%4) +: 8];
      end
   endtask

   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] data);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.data = data;
      return x;
   endfunction

   // Single non-pipelined transfer; called and returns at posedge+1 with an idle data phase.
   task automatic xfer(input int d, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int nlow, output logic [1:0] resp_low,
                       output logic [1:0] resp_fin, output logic [31:0] rdata);
      hsel[d]   = 1'b1;
      htrans[d] = 2'd2;
      hburst[d] = 3'($urandom_range(0, 7));
      hsize[d]  = size;
      hwrite[d] = wr;
      haddr[d]  = addr;
      @(posedge clk); #1;
      hsel[d]   = 1'b0;
      htrans[d] = 2'd0;
      haddr[d]  = $urandom;
      hwdata[d] = wdata;
      nlow      = 0;
      resp_low  = 2'd0;
      while (hready[d] !== 1'b1 && nlow < 40) begin
         resp_low = hresp[d];
         nlow++;
         @(posedge clk); #1;
      end
      check_eq("xfer_ready", 32'(hready[d]), 32'd1);
      resp_fin = hresp[d];
      rdata    = hrdata[d];
      @(posedge clk); #1;
      hwdata[d] = $urandom;
   endtask

   task automatic do_access(input int d, input logic wr, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
      int          nlow;
      logic [1:0]  resp_low, resp_fin;
      logic [31:0] rdata, exp_rd;
      bit          bad;
      bad    = illegal(size, addr);
      exp_rd = (!bad && !wr) ? mdl_word(d, addr) : hrdata[d];
      xfer(d, wr, size, addr, wdata, nlow, resp_low, resp_fin, rdata);
      check_eq("wait_cycles", 32'(nlow), bad ? 32'd1 : 32'(ws_of(d)));
      if (nlow > 0) check_eq("resp_low", 32'(resp_low), bad ? 32'd1 : 32'd0);
      check_eq("resp_final", 32'(resp_fin), bad ? 32'd1 : 32'd0);
      check_eq((wr || bad) ? "rdata_hold" : "rdata", rdata, exp_rd);
      check_eq("resp_after", 32'(hresp[d]), 32'd0);
      if (!bad && wr) mdl_write(d, size, addr, wdata);
      $display("dut%0d %s size=%0d addr=%h data=%h err=%0d waits=%0d",
               d, wr ? "W" : "R", size, addr, wr ? wdata : rdata, bad, nlow);
   endtask

   // Back-to-back pipelined stream; only used on the zero-wait instance.
   task automatic pipe_run(input int d, input xfer_t q[$]);
      xfer_t       prev;
      bit          have;
      bit          act;
      logic [31:0] last_rd;
      have    = 1'b0;
      prev    = '0;
      last_rd = hrdata[d];
      for (int c = 0; c <= q.size(); c++) begin
         if (have) begin
            act = prev.sel && (prev.trans == 2'd2 || prev.trans == 2'd3);
            check_eq("pipe_hready", 32'(hready[d]), 32'd1);
            check_eq("pipe_hresp", 32'(hresp[d]), 32'd0);
            if (act && !prev.wr) check_eq("pipe_rdata", hrdata[d], mdl_word(d, prev.addr));
            else check_eq("pipe_hold", hrdata[d], last_rd);
            last_rd = hrdata[d];
            if (act && prev.wr) begin
               hwdata[d] = prev.data;
               mdl_write(d, prev.size, prev.addr, prev.data);
            end else begin
               hwdata[d] = $urandom;
            end
            $display("dut%0d pipe sel=%0d trans=%0d %s size=%0d addr=%h data=%h", d,
                     prev.sel, prev.trans, prev.wr ? "W" : "R", prev.size, prev.addr,
                     prev.wr ? hwdata[d] : hrdata[d]);
         end
         if (c < q.size()) begin
            hsel[d]   = q[c].sel;
            htrans[d] = q[c].trans;
            hwrite[d] = q[c].wr;
            hsize[d]  = q[c].size;
            haddr[d]  = q[c].addr;
            hburst[d] = 3'($urandom_range(0, 7));
            prev      = q[c];
            have      = 1'b1;
         end else begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'd0;
            have      = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic rand_access(input int d);
      logic [2:0]  size;
      logic [31:0] addr;
      if ($urandom_range(0, 99) < 70) begin
         size = 3'($urandom_range(0, 2));
         addr = 32'($urandom_range(0, 255)) & ~((32'd1 << size) - 32'd1);
      end else begin
         case ($urandom_range(0, 3))
            0: begin size = 3'($urandom_range(3, 7)); addr = 32'($urandom_range(0, 255)); end
            1: begin size = 3'd1; addr = 32'($urandom_range(0, 255)) | 32'd1; end
            2: begin size = 3'd2; addr = (32'($urandom_range(0, 255)) & ~32'd3) |
                                         32'($urandom_range(1, 3)); end
            default: begin size = 3'($urandom_range(0, 2));
                           addr = 32'd1024 + (32'($urandom_range(0, 4095)) << 2); end
         endcase
      end
      do_access(d, 1'($urandom_range(0, 1)), size, addr, $urandom);
   endtask

   initial begin
      xfer_t q[$];
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; hsel[d] = 1'b0; htrans[d] = 2'd0; hburst[d] = 3'd0;
         hsize[d] = 3'd0; hwrite[d] = 1'b0; haddr[d] = 32'd0; hwdata[d] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq("rst_hready", 32'(hready[d]), 32'd1);
         check_eq("rst_hresp", 32'(hresp[d]), 32'd0);
         check_eq("rst_hrdata", hrdata[d], 32'd0);
         rst[d] = 1'b0;
      end
      @(posedge clk); #1;

      // Preload words 0..63 of each instance.
      q = {};
      for (int w = 0; w < 64; w++) q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'(w * 4), $urandom));
      pipe_run(0, q);
      for (int d = 1; d < 3; d++)
         for (int w = 0; w < 64; w++) do_access(d, 1'b1, 3'd2, 32'(w * 4), $urandom);

      // Zero-wait write then pipelined read of the same word.
      q = {};
      q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
      q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0));
      pipe_run(0, q);
      check_eq("fwd_value", hrdata[0], 32'hDEADBEEF);

      // Byte and halfword lanes merging into one word.
      q = {};
      q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h00000000));
      q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, 32'h0000AA00));
      q.push_back(mk(1'b1, 2'd3, 1'b1, 3'd1, 32'h22, 32'h55550000));
      q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0));
      pipe_run(0, q);
      check_eq("merge_value", hrdata[0], 32'h5555AA00);

      // Random pipelined mix with IDLE, BUSY and deselected slots.
      q = {};
      for (int i = 0; i < 120; i++) begin
         logic [2:0] sz;
         sz = 3'($urandom_range(0, 2));
         if ($urandom_range(0, 99) < 70)
            q.push_back(mk(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz,
                           32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1), $urandom));
         else case ($urandom_range(0, 2))
            0: q.push_back(mk(1'b1, 2'd0, 1'b1, 3'd2, 32'($urandom_range(0, 63)) << 2, $urandom));
            1: q.push_back(mk(1'b1, 2'd1, 1'b1, 3'd2, 32'($urandom_range(0, 63)) << 2, $urandom));
            default: q.push_back(mk(1'b0, 2'd2, 1'b1, 3'd2, 32'($urandom_range(0, 63)) << 2, $urandom));
         endcase
      end
      pipe_run(0, q);

      // Two-wait read, then the illegal-access set, each followed by a read-back.
      do_access(1, 1'b0, 3'd2, 32'h0, 32'h0);
      do_access(1, 1'b1, 3'd2, 32'h2, 32'h12345678);
      do_access(1, 1'b0, 3'd2, 32'h0, 32'h0);
      do_access(1, 1'b1, 3'd3, 32'h0, 32'h87654321);
      do_access(1, 1'b0, 3'd2, 32'h0, 32'h0);
      do_access(1, 1'b1, 3'd2, 32'd1024, 32'hA5A5A5A5);
      do_access(1, 1'b1, 3'd1, 32'h5, 32'h5A5A5A5A);
      do_access(1, 1'b0, 3'd2, 32'h4, 32'h0);

      // Reset during the second wait cycle of a write to word 4.
      do_access(2, 1'b1, 3'd2, 32'h10, 32'h11223344);
      do_access(2, 1'b0, 3'd2, 32'h10, 32'h0);
      hsel[2] = 1'b1; htrans[2] = 2'd2; hwrite[2] = 1'b1; hsize[2] = 3'd2; haddr[2] = 32'h10;
      @(posedge clk); #1;
      hsel[2] = 1'b0; htrans[2] = 2'd0; hwdata[2] = 32'hCAFEF00D;
      check_eq("rstw_wait1", 32'(hready[2]), 32'd0);
      @(posedge clk); #1;
      check_eq("rstw_wait2", 32'(hready[2]), 32'd0);
      rst[2] = 1'b1;
      #1;
      check_eq("rstw_hready", 32'(hready[2]), 32'd1);
      check_eq("rstw_hresp", 32'(hresp[2]), 32'd0);
      check_eq("rstw_hrdata", hrdata[2], 32'd0);
      @(posedge clk); #1;
      rst[2] = 1'b0;
      @(posedge clk); #1;
      do_access(2, 1'b0, 3'd2, 32'h10, 32'h0);
      check_eq("rstw_mem", hrdata[2], 32'h11223344);

      for (int i = 0; i < 60; i++) begin
         rand_access(1);
         rand_access(2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB responder (slave) with on-chip word memory: decodes pipelined address/data-phase transfers from an AHB master, drives HREADY/HRESP/HRDATA, and stores write data with byte-lane masking. It is the RTL slave end of the AHB bus that the master driver and bus-protocol assertions exercise. It inserts a configurable number of wait states and issues the two-cycle ERROR response for illegal accesses.

## Interface
- MEM_WORDS, 256: memory depth in 32-bit words; legal byte addresses are 0 to MEM_WORDS*4-1 (power of two).
- WAIT_STATES, 0: HREADY-low cycles inserted in every OKAY NONSEQ/SEQ data phase (0-15).

- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HBURST  in  3  burst type; accepted, not used for decode.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; 3-7 illegal.
- HWRITE  in  1  1 write, 0 read.
- HADDR  in  32  byte address.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  out  1  transfer-complete / address-accept.
- HRESP  out  2  0 OKAY, 1 ERROR; 2/3 never driven.
- HRDATA  out  32  read data.

## Operation
- Address phase is sampled on a rising edge when HREADY=1. A transfer is active when HSEL=1 and HTRANS is NONSEQ or SEQ. IDLE, BUSY, or HSEL=0 gives a zero-wait OKAY data phase with no memory access.
- A transfer is illegal when any of the following holds:
  - HADDR >= MEM_WORDS*4;
  - HSIZE > 2;
  - HSIZE=1 and HADDR[0]=1;
  - HSIZE=2 and HADDR[1:0]!=0.
- Word index = HADDR[log2(MEM_WORDS)+1:2].
- Byte-lane enables (little-endian):
  - size 0: lane HADDR[1:0];
  - size 1: lanes {HADDR[1],0} and {HADDR[1],1};
  - size 2: all four lanes.
- Registered address-phase controls: write flag, word index, lane enables.
- FSM states:
  - OKAY_IDLE: HREADY=1, HRESP=0. On an active legal transfer, go to WAIT if WAIT_STATES>0, else stay (zero-wait data phase). On an illegal transfer, go to ERR1.
  - WAIT: HREADY=0, HRESP=0. A counter decrements from WAIT_STATES-1; at 0, go to OKAY_IDLE, which is the final data-phase cycle.
  - ERR1: HREADY=0, HRESP=1. Go to ERR2.
  - ERR2: HREADY=1, HRESP=1. Samples the next address phase exactly like OKAY_IDLE.
- Writes: HWDATA enabled lanes are committed to memory on the edge that ends the data phase (HREADY=1). Disabled lanes are unchanged. Errored writes commit nothing.
- Reads: HRDATA is loaded with the full addressed word at the edge that begins the final OKAY data-phase cycle. HRDATA holds its value otherwise, including through IDLE, BUSY and ERROR.
- Forwarding: when a write commits on the same edge that loads HRDATA for the same word, HRDATA gets the merged word (new lanes from HWDATA, others from memory).
- Memory is not reset.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, FSM=OKAY_IDLE, wait counter=0, registered controls cleared (no pending write).
- Reset asserted mid-transfer abandons the transfer. The pending write is not committed; memory holds its prior contents.
- Zero-wait read: address at edge k; HRDATA valid from edge k until edge k+1.
- Wait read/write: address at edge k; HREADY=0 during cycles k..k+N-1, where N=WAIT_STATES. HREADY=1 in cycle k+N. Read data loads at edge k+N; write commits at edge k+N+1.
- While HREADY=0, the master's next address is held and not sampled.
- Error: address at edge k; ERR1 is cycle k (HREADY=0, HRESP=1); ERR2 is cycle k+1 (HREADY=1, HRESP=1). The next address is sampled at edge k+2.
- Pipelined back-to-back transfers at WAIT_STATES=0 sustain one transfer per cycle.
- Write then read of the same word at WAIT_STATES=0 returns the new data via forwarding.

## Test plan
- Reset mid-WAIT (WAIT_STATES=3): assert HRESET in the 2nd wait cycle of a write to word 4, which previously held 0x11223344. Outputs go to reset values immediately; word 4 still reads 0x11223344.
- WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then pipelined read of 0x10. HRDATA=0xDEADBEEF in the read's data phase (forwarding); HREADY=1 throughout.
- Byte/halfword merge: word 0x20=0x00000000.
  - Write byte 0xAA to 0x21 (HWDATA=0x0000AA00).
  - Write halfword 0x5555 to 0x22 (HWDATA=0x55550000).
  - Word read of 0x20 returns 0x5555AA00.
- WAIT_STATES=2 read of 0x0: HREADY low exactly 2 cycles, then 1 cycle HREADY=1 with HRESP=0 and correct HRDATA.
- Illegal accesses, each giving exactly ERR1 then ERR2 and no memory change:
  - word access at 0x2;
  - HSIZE=3;
  - address MEM_WORDS*4.
  
  The master issues IDLE in ERR2, and the following cycle shows HRESP=0.
- BUSY/IDLE and HSEL=0 between accesses: HREADY=1, HRESP=0, HRDATA unchanged, no memory write.
